// File: rtl/wb_pkg.sv
// Shared writeback definitions: widths, arbiter state encoding and
// the MemToReg select codes used by the upstream writeback mux.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        S_PIPE  = 1'b0,
        S_FORCE = 1'b1
    } wb_state_e;

    typedef enum logic [2:0] {
        MTR_ALU    = 3'd0,
        MTR_MEM    = 3'd1,
        MTR_PC4    = 3'd2,
        MTR_IMM    = 3'd3,
        MTR_PC_IMM = 3'd4
    } mem_to_reg_e;

endpackage

// File: rtl/rf_wb_starve_ctr.sv
// Starvation counter and S_PIPE/S_FORCE FSM for the writeback arbiter.
// force_llu flips priority to the long-latency unit for one grant.
module rf_wb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic llu_valid,
    input  logic grant_llu,
    output logic force_llu
);
    import wb_pkg::*;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_state_e  state;
    wb_state_e  state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] cnt_inc;

    assign cnt_inc   = cnt + 4'd1;
    assign force_llu = (state == S_FORCE);

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PIPE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Count denied llu cycles; switch to forced grant at the limit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_PIPE: begin
                if (!llu_valid || grant_llu) begin
                    cnt_nxt = 4'd0;
                end else if (cnt != LIMIT) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == LIMIT) begin
                        state_nxt = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                if (grant_llu || !llu_valid) begin
                    state_nxt = S_PIPE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = S_PIPE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs long-latency unit.
// Optional macro WB_BYPASS_EN adds a combinational bypass of the winner.
module rf_wb_arbiter #(
    parameter int XLEN         = wb_pkg::XLEN,
    parameter int REG_AW       = wb_pkg::REG_AW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    output logic              pipe_ready,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    input  logic              llu_valid,
    output logic              llu_ready,
    input  logic [REG_AW-1:0] llu_rd,
    input  logic [XLEN-1:0]   llu_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              stall_pipe
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [REG_AW-1:0] byp_rd,
    output logic [XLEN-1:0]   byp_data
`endif
);
    import wb_pkg::*;

    logic              force_llu;
    logic              grant_pipe;
    logic              grant_llu;
    logic              grant_any;
    logic [REG_AW-1:0] win_rd;
    logic [XLEN-1:0]   win_data;

    rf_wb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .llu_valid (llu_valid),
        .grant_llu (grant_llu),
        .force_llu (force_llu)
    );

    // Priority grant: pipe first unless a forced llu grant is due
    always_comb begin
        grant_pipe = 1'b0;
        grant_llu  = 1'b0;
        if (!rst) begin
            if (force_llu) begin
                grant_llu  = llu_valid;
                grant_pipe = !llu_valid && pipe_valid;
            end else begin
                grant_pipe = pipe_valid;
                grant_llu  = !pipe_valid && llu_valid;
            end
        end
    end

    assign grant_any  = grant_pipe || grant_llu;
    assign win_rd     = grant_llu ? llu_rd   : pipe_rd;
    assign win_data   = grant_llu ? llu_data : pipe_data;
    assign pipe_ready = grant_pipe;
    assign llu_ready  = grant_llu;
    assign stall_pipe = pipe_valid && grant_llu;

`ifdef WB_BYPASS_EN
    assign byp_valid = grant_any && (win_rd != '0);
    assign byp_rd    = win_rd;
    assign byp_data  = win_data;
`endif

    // Registered write port; x0 writes complete but never assert rf_we
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (grant_any) begin
            rf_we    <= (win_rd != '0);
            rf_rd    <= win_rd;
            rf_wdata <= win_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT=4).
// Define WB_BYPASS_EN for both bench and RTL to exercise the bypass.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic        pipe_ready;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        stall_pipe;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
`endif

    int vecs;
    int fails;

    rf_wb_arbiter #(
        .XLEN(32),
        .REG_AW(5),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_ready (pipe_ready),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .llu_valid  (llu_valid),
        .llu_ready  (llu_ready),
        .llu_rd     (llu_rd),
        .llu_data   (llu_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .stall_pipe (stall_pipe)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid  (byp_valid),
        .byp_rd     (byp_rd),
        .byp_data   (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready/stall pattern for the current cycle
    task automatic chk_hs(input string tag, input logic pr,
                          input logic lr, input logic st);
        #1;
        chk({tag, ".pipe_ready"}, 32'(pipe_ready), 32'(pr));
        chk({tag, ".llu_ready"},  32'(llu_ready),  32'(lr));
        chk({tag, ".stall_pipe"}, 32'(stall_pipe), 32'(st));
    endtask

    task automatic chk_rf(input string tag, input logic we,
                          input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".rf_we"},    32'(rf_we), 32'(we));
        chk({tag, ".rf_rd"},    32'(rf_rd), 32'(rd));
        chk({tag, ".rf_wdata"}, rf_wdata,   d);
    endtask

    // Pipe held busy, llu waits four denied cycles then is forced in
    task automatic contend(input string tag, input logic [4:0] prd,
                           input logic [31:0] pd, input logic [4:0] lrd,
                           input logic [31:0] ld);
        pipe_valid = 1'b1;
        pipe_rd    = prd;
        pipe_data  = pd;
        llu_valid  = 1'b1;
        llu_rd     = lrd;
        llu_data   = ld;
        for (int i = 1; i <= 4; i++) begin
            chk_hs($sformatf("%s.deny%0d", tag, i), 1'b1, 1'b0, 1'b0);
            tick();
            chk_rf($sformatf("%s.deny%0d", tag, i), prd != 0, prd, pd);
        end
        chk_hs({tag, ".force"}, 1'b0, 1'b1, 1'b1);
        tick();
        llu_valid = 1'b0;
        chk_rf({tag, ".llu_wr"}, lrd != 0, lrd, ld);
        chk_hs({tag, ".after"}, 1'b1, 1'b0, 1'b0);
        tick();
        chk_rf({tag, ".pipe_wr"}, prd != 0, prd, pd);
    endtask

    initial begin
        vecs       = 0;
        fails      = 0;
        rst        = 1'b1;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd3;
        pipe_data  = 32'h33;
        llu_valid  = 1'b1;
        llu_rd     = 5'd4;
        llu_data   = 32'h44;

        // Reset with both requesters pending
        tick();
        chk_hs("rst1", 1'b0, 1'b0, 1'b0);
        tick();
        chk_hs("rst2", 1'b0, 1'b0, 1'b0);
        chk_rf("rst", 1'b0, 5'd0, 32'h0);

        // Release: pipe wins first
        rst = 1'b0;
        chk_hs("release", 1'b1, 1'b0, 1'b0);
        tick();
        chk_rf("release", 1'b1, 5'd3, 32'h33);

        // Pipe only
        llu_valid = 1'b0;
        pipe_rd   = 5'd5;
        pipe_data = 32'h1234;
        chk_hs("pipe_only", 1'b1, 1'b0, 1'b0);
        tick();
        chk_rf("pipe_only", 1'b1, 5'd5, 32'h1234);

        // Idle: rf_we drops, address/data hold
        pipe_valid = 1'b0;
        chk_hs("idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk_rf("idle", 1'b0, 5'd5, 32'h1234);

        // Starvation forces one llu grant
        contend("starve", 5'd6, 32'h66, 5'd9, 32'hDEADBEEF);

        // x0 writes from pipe then llu
        pipe_rd   = 5'd0;
        pipe_data = 32'hFFFFFFFF;
        chk_hs("x0_pipe", 1'b1, 1'b0, 1'b0);
        tick();
        chk_rf("x0_pipe", 1'b0, 5'd0, 32'hFFFFFFFF);
        pipe_valid = 1'b0;
        llu_valid  = 1'b1;
        llu_rd     = 5'd0;
        llu_data   = 32'hABCD;
        chk_hs("x0_llu", 1'b0, 1'b1, 1'b0);
        tick();
        chk_rf("x0_llu", 1'b0, 5'd0, 32'hABCD);

        // Flush abort while in S_FORCE
        pipe_valid = 1'b1;
        pipe_rd    = 5'd10;
        pipe_data  = 32'hA0;
        llu_rd     = 5'd11;
        llu_data   = 32'hB0;
        for (int i = 1; i <= 4; i++) begin
            chk_hs($sformatf("flush.deny%0d", i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        llu_valid = 1'b0;
        chk_hs("flush.abort", 1'b1, 1'b0, 1'b0);
        tick();
        chk_rf("flush.abort", 1'b1, 5'd10, 32'hA0);
        // Counter must have restarted from zero
        contend("reforce", 5'd12, 32'hC0, 5'd13, 32'hD0);

        // Reset mid-contention
        llu_valid = 1'b1;
        llu_rd    = 5'd14;
        llu_data  = 32'hE0;
        chk_hs("mid.deny", 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        chk_hs("mid.rst", 1'b0, 1'b0, 1'b0);
        tick();
        chk_rf("mid.rst", 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        contend("mid.restart", 5'd15, 32'hF0, 5'd16, 32'h160);

`ifdef WB_BYPASS_EN
        // Bypass shows the winner in the grant cycle
        pipe_rd   = 5'd7;
        pipe_data = 32'h42;
        #1;
        chk("byp.valid", 32'(byp_valid), 32'd1);
        chk("byp.rd",    32'(byp_rd),    32'd7);
        chk("byp.data",  byp_data,       32'h42);
        chk("byp.rf_we", 32'(rf_we),     32'd1);
        chk("byp.rf_rd", 32'(rf_rd),     32'd15);
        tick();
        chk_rf("byp.wr", 1'b1, 5'd7, 32'h42);
`endif

        pipe_valid = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single register-file write port. Arbitrates between two requesters:
  - the in-order pipeline writeback, i.e. the already-selected rd write data;
  - a long-latency unit (multiply/divide or a late load) that returns results out of band.
- Pipeline has priority. A starvation counter forces one long-latency grant by stalling the pipeline for one cycle.
- Output is registered and drives the register file write port directly.

Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register address width.
- STARVE_LIMIT, 4, consecutive denied cycles before a forced long-latency grant; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- pipe_valid  in  1  pipeline has a writeback this cycle.
- pipe_ready  out  1  pipeline writeback accepted this cycle.
- pipe_rd  in  REG_AW  destination register.
- pipe_data  in  XLEN  write data.
- llu_valid  in  1  long-latency result pending.
- llu_ready  out  1  long-latency result accepted this cycle.
- llu_rd  in  REG_AW  destination register.
- llu_data  in  XLEN  result data.
- rf_we  out  1  register-file write enable.
- rf_rd  out  REG_AW  write address.
- rf_wdata  out  XLEN  write data.
- stall_pipe  out  1  high when the pipeline is refused because of a forced grant (drives hazard-unit stall).

Behaviour:
- Clock and reset: clock port clk; reset port rst, synchronous, active-high. Reset clears all registers:
  - rf_we=0, rf_rd=0, rf_wdata=0;
  - state=S_PIPE, starve_cnt=0.
- pipe_ready and llu_ready are forced 0 while rst=1.
- Handshakes: standard valid/ready. A transfer happens when valid&&ready in the same cycle.
  - Requesters hold rd and data stable while valid && !ready.
  - valid is never dropped before acceptance, except by reset or by an llu flush that deasserts llu_valid.
- Grant is combinational from the current state and the valids:
  - S_PIPE: grant pipe if pipe_valid. Otherwise grant llu if llu_valid.
  - S_FORCE: grant llu if llu_valid. Otherwise grant pipe if pipe_valid.
  - pipe_ready = grant_pipe; llu_ready = grant_llu; stall_pipe = pipe_valid && grant_llu.
  - At most one grant per cycle.
- Output register, 1-cycle latency. On the edge ending a grant cycle:
  - rf_we <= (granted rd != 0);
  - rf_rd and rf_wdata <= the winner's rd and data.
  - With no grant, rf_we <= 0 and rf_rd/rf_wdata hold their values.
  - A write to x0 completes the handshake but never raises rf_we.
- starve_cnt, 4 bits:
  - In S_PIPE with llu_valid && !grant_llu: increment.
  - On grant_llu, or when llu_valid is low: clear.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - S_PIPE -> S_FORCE when the incremented count equals STARVE_LIMIT. The forced grant occurs in the next cycle.
  - S_FORCE -> S_PIPE on grant_llu, or when llu_valid deasserts (flush abort). Either way starve_cnt is cleared.
- Worst-case llu wait: STARVE_LIMIT denied cycles, then the grant. The write is visible on rf_* one cycle after the grant.
- Same rd from both requesters: no merging. Writes occur in grant order and the later write wins. WAW ordering is the scoreboard's responsibility, not this block's.
- Reset mid-operation: pending valids are ignored in the reset cycle. Arbitration restarts in S_PIPE with starve_cnt=0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs byp_valid (1), byp_rd (REG_AW), byp_data (XLEN).
  - They carry the current-cycle winner, combinationally, before the output register.
  - byp_valid = (grant_pipe||grant_llu) && winner_rd != 0.
  - Lets the ID stage forward one cycle early.
- Undefined: these ports do not exist. Forwarding is only possible from rf_* one cycle later.

Decomposition:
- Shared package wb_pkg:
  - XLEN, REG_AW;
  - the arbiter state encoding (S_PIPE=1'b0, S_FORCE=1'b1);
  - the MemToReg select encodings used by the upstream writeback mux (ALU, MEM, PC+4, IMM, PC+IMM = 3'd0..3'd4).
- One natural sub-module: rf_wb_starve_ctr, holding the saturating counter plus the S_PIPE/S_FORCE FSM. It outputs force_llu.

Test Plan:
- Reset: rst=1 for 2 cycles with both valids high -> both readys 0, rf_we=0, rf_rd=0, rf_wdata=0. After release, pipe is granted first.
- Pipe only: pipe_valid, rd=5, data=0x1234 -> pipe_ready=1 the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
- Contention, STARVE_LIMIT=4: pipe_valid held high, llu_valid with rd=9, data=0xDEADBEEF from cycle 1:
  - llu denied in cycles 1-4;
  - cycle 5: llu_ready=1, pipe_ready=0, stall_pipe=1;
  - cycle 6: rf_rd=9, rf_wdata=0xDEADBEEF;
  - cycle 6: pipe granted again.
- x0 write: pipe rd=0, data=0xFFFFFFFF -> pipe_ready=1 and rf_we stays 0. Repeat with llu rd=0 -> same.
- Flush abort: reach S_FORCE, then drop llu_valid before the grant -> state returns to S_PIPE, starve_cnt=0, pipe granted that cycle, no llu write.
- WB_BYPASS_EN: pipe rd=7, data=0x42 -> byp_valid=1, byp_rd=7, byp_data=0x42 in the grant cycle, one cycle before rf_we. Built without the macro, the ports are absent.
